// File: rtl/inst_fetch.sv
// Instruction fetch stage: drives the instruction ROM from an internal pc and queues fetched words
// in a small FIFO toward decode. Define FETCH_MISALIGN_CHK_EN to trap misaligned branch targets.
module inst_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_inst,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        exc_misalign
);

    localparam logic [1:0] DEPTH_CNT = 2'(BUF_DEPTH);

    logic [31:0] pc_q, pc_d;
    logic        rom_ce_q;
    logic [1:0]  count_q, count_d;
    logic [31:0] inst_buf_q [BUF_DEPTH];
    logic [31:0] inst_buf_d [BUF_DEPTH];
    logic [31:0] pc_buf_q   [BUF_DEPTH];
    logic [31:0] pc_buf_d   [BUF_DEPTH];

    logic        dequeue;
    logic        fetch;
    logic        fetch_halt;
    logic [31:0] branch_pc;
    logic [1:0]  wr_idx;

    assign rom_addr = pc_q;
    assign rom_ce   = rom_ce_q;

    // Entry 0 is always the head; it is left untouched when the buffer drains so the outputs hold.
    assign if_valid = (count_q != 2'd0) && !branch_flag;
    assign if_inst  = inst_buf_q[0];
    assign if_pc    = pc_buf_q[0];

    assign dequeue = if_valid && if_ready;
    assign fetch   = rom_ce_q && !branch_flag && !fetch_halt &&
                     ((count_q < DEPTH_CNT) || dequeue);
    assign wr_idx  = dequeue ? (count_q - 2'd1) : count_q;

`ifdef FETCH_MISALIGN_CHK_EN
    logic exc_q, exc_d;
    logic halt_q, halt_d;

    assign branch_pc    = branch_target;
    assign exc_misalign = exc_q;
    assign fetch_halt   = halt_q;

    // Every branch re-evaluates alignment, so an aligned redirect is the only way out of a halt.
    always_comb begin
        exc_d  = exc_q;
        halt_d = halt_q;
        if (branch_flag) begin
            exc_d  = |branch_target[1:0];
            halt_d = |branch_target[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exc_q  <= 1'b0;
            halt_q <= 1'b0;
        end else begin
            exc_q  <= exc_d;
            halt_q <= halt_d;
        end
    end
`else
    logic unused_target_bits;

    assign unused_target_bits = ^branch_target[1:0];
    assign branch_pc          = {branch_target[31:2], 2'b00};
    assign exc_misalign       = 1'b0;
    assign fetch_halt         = 1'b0;
`endif

    always_comb begin
        pc_d = pc_q;
        if (branch_flag) begin
            pc_d = branch_pc;
        end else if (fetch) begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_comb begin
        count_d = count_q;
        if (branch_flag) begin
            count_d = 2'd0;
        end else if (fetch && !dequeue) begin
            count_d = count_q + 2'd1;
        end else if (!fetch && dequeue) begin
            count_d = count_q - 2'd1;
        end
    end

    // Branch cycles never dequeue or fetch, so leaving the storage alone there is a flush.
    always_comb begin
        inst_buf_d = inst_buf_q;
        pc_buf_d   = pc_buf_q;
        if (dequeue) begin
            for (int i = 0; i < BUF_DEPTH - 1; i++) begin
                if ((i + 1) < int'(count_q)) begin
                    inst_buf_d[i] = inst_buf_q[i + 1];
                    pc_buf_d[i]   = pc_buf_q[i + 1];
                end
            end
        end
        if (fetch) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                if (int'(wr_idx) == i) begin
                    inst_buf_d[i] = rom_inst;
                    pc_buf_d[i]   = pc_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            rom_ce_q <= 1'b0;
            count_q  <= 2'd0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                inst_buf_q[i] <= 32'd0;
                pc_buf_q[i]   <= 32'd0;
            end
        end else begin
            pc_q       <= pc_d;
            rom_ce_q   <= 1'b1;
            count_q    <= count_d;
            inst_buf_q <= inst_buf_d;
            pc_buf_q   <= pc_buf_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: the stimulus side predicts the instruction stream decode should
// see, a free-running monitor pops and compares it whenever the fetch stage presents an entry.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        exc_misalign;

    int          total = 0;
    int          bad = 0;
    int          delivered = 0;
    int          since_reset = 0;
    logic        halted = 1'b0;
    logic [31:0] model_next_pc;
    entry_t      exp_q[$];

    inst_fetch #(
        .RESET_PC (RESET_PC),
        .BUF_DEPTH(2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rom_ce       (rom_ce),
        .rom_addr     (rom_addr),
        .rom_inst     (rom_inst),
        .branch_flag  (branch_flag),
        .branch_target(branch_target),
        .if_valid     (if_valid),
        .if_ready     (if_ready),
        .if_inst      (if_inst),
        .if_pc        (if_pc),
        .exc_misalign (exc_misalign)
    );

    always #5 clk = ~clk;

    // ROM word k holds the value k.
    assign rom_inst = rom_addr >> 2;

    function automatic void topUp();
        while (exp_q.size() < 32) begin
            exp_q.push_back('{pc: model_next_pc, inst: model_next_pc >> 2});
            model_next_pc = model_next_pc + 32'd4;
        end
    endfunction

    function automatic void redirect(input logic [31:0] start);
        exp_q.delete();
        halted        = 1'b0;
        model_next_pc = start;
        topUp();
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rdy, input logic br, input logic [31:0] tgt);
        @(negedge clk);
        if_ready      = rdy;
        branch_flag   = br;
        branch_target = tgt;
        since_reset++;
        if (br) begin
`ifdef FETCH_MISALIGN_CHK_EN
            if (tgt[1:0] != 2'b00) begin
                exp_q.delete();
                halted = 1'b1;
            end else begin
                redirect(tgt);
            end
`else
            redirect({tgt[31:2], 2'b00});
`endif
        end else if (!halted) begin
            topUp();
        end
    endtask

    task automatic doReset(input logic rdy);
        @(negedge clk);
        rst_n       = 1'b0;
        branch_flag = 1'b0;
        if_ready    = rdy;
        redirect(RESET_PC);
        #1;
        checkOutput("rst_if_valid", 32'(if_valid), 32'd0);
        checkOutput("rst_if_pc", if_pc, 32'd0);
        checkOutput("rst_if_inst", if_inst, 32'd0);
        checkOutput("rst_rom_ce", 32'(rom_ce), 32'd0);
        checkOutput("rst_rom_addr", rom_addr, RESET_PC);
        checkOutput("rst_exc", 32'(exc_misalign), 32'd0);
        @(negedge clk);
        rst_n       = 1'b1;
        since_reset = 0;
    endtask

    // Monitor: the head entry must match the predicted stream whenever it is presented.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1 && if_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_valid: got if_pc=%h with no entry expected", if_pc);
                end else begin
                    checkOutput("head_pc", if_pc, exp_q[0].pc);
                    checkOutput("head_inst", if_inst, exp_q[0].inst);
                    if (if_ready === 1'b1) begin
                        void'(exp_q.pop_front());
                        delivered++;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        total++;
        bad++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          d0;
        logic        rdy;
        logic        br;
        logic [31:0] tgt;

        rst_n         = 1'b0;
        if_ready      = 1'b0;
        branch_flag   = 1'b0;
        branch_target = 32'd0;
        redirect(RESET_PC);

        // Start-up latency and back-to-back delivery.
        doReset(1'b1);
        @(posedge clk); #1;
        checkOutput("ce_after_release", 32'(rom_ce), 32'd1);
        checkOutput("valid_first_edge", 32'(if_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0);
        @(posedge clk); #1;
        checkOutput("first_valid", 32'(if_valid), 32'd1);
        checkOutput("first_pc", if_pc, RESET_PC);
        checkOutput("first_inst", if_inst, RESET_PC >> 2);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 32'd0);
            @(posedge clk); #1;
            checkOutput("no_bubble", 32'(if_valid), 32'd1);
        end

        // Backpressure fills the buffer and freezes the ROM address.
        doReset(1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 32'd0);
        @(posedge clk); #1;
        checkOutput("full_rom_addr", rom_addr, RESET_PC + 32'd8);
        checkOutput("full_rom_ce", 32'(rom_ce), 32'd1);
        checkOutput("full_head_pc", if_pc, RESET_PC);
        d0 = delivered;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'd0);
        @(posedge clk); #1;
        checkOutput("drain_count", 32'(delivered - d0), 32'd3);

        // Redirect while full: no dequeue, target appears two edges later.
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'd0);
        applyStimulus(1'b1, 1'b1, 32'h0000_0100);
        #1;
        checkOutput("branch_forces_invalid", 32'(if_valid), 32'd0);
        @(posedge clk); #1;
        checkOutput("branch_rom_addr", rom_addr, 32'h0000_0100);
        checkOutput("branch_flush_valid", 32'(if_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0);
        @(posedge clk); #1;
        checkOutput("branch_target_valid", 32'(if_valid), 32'd1);
        checkOutput("branch_target_pc", if_pc, 32'h0000_0100);
        checkOutput("branch_target_inst", if_inst, 32'h0000_0040);

        // pc wraps modulo 2^32.
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF8);
        applyStimulus(1'b1, 1'b0, 32'd0);
        @(posedge clk); #1;
        checkOutput("wrap_pc0", if_pc, 32'hFFFF_FFF8);
        applyStimulus(1'b1, 1'b0, 32'd0);
        @(posedge clk); #1;
        checkOutput("wrap_pc1", if_pc, 32'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b0, 32'd0);
        @(posedge clk); #1;
        checkOutput("wrap_pc2", if_pc, 32'h0000_0000);

        // Misaligned branch target.
        applyStimulus(1'b1, 1'b1, 32'h0000_0102);
        @(posedge clk); #1;
`ifdef FETCH_MISALIGN_CHK_EN
        checkOutput("misalign_exc", 32'(exc_misalign), 32'd1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 32'd0);
            @(posedge clk); #1;
            checkOutput("halt_no_valid", 32'(if_valid), 32'd0);
        end
        applyStimulus(1'b1, 1'b1, 32'h0000_0200);
        @(posedge clk); #1;
        checkOutput("realign_exc", 32'(exc_misalign), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0);
        @(posedge clk); #1;
        checkOutput("resume_valid", 32'(if_valid), 32'd1);
        checkOutput("resume_pc", if_pc, 32'h0000_0200);
`else
        checkOutput("misalign_exc_tied", 32'(exc_misalign), 32'd0);
        checkOutput("misalign_rom_addr", rom_addr, 32'h0000_0100);
        applyStimulus(1'b1, 1'b0, 32'd0);
        @(posedge clk); #1;
        checkOutput("misalign_valid", 32'(if_valid), 32'd1);
        checkOutput("misalign_pc", if_pc, 32'h0000_0100);
`endif

        // Reset pulse with a full buffer discards everything.
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'd0);
        @(posedge clk); #1;
        checkOutput("pre_reset_valid", 32'(if_valid), 32'd1);
        doReset(1'b1);
        @(posedge clk); #1;
        checkOutput("restart_rom_addr", rom_addr, RESET_PC);
        checkOutput("restart_no_valid", 32'(if_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'd0);
        @(posedge clk); #1;
        checkOutput("restart_pc", if_pc, RESET_PC);

        // Randomized traffic: backpressure, redirects and occasional resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rdy = ($urandom_range(0, 3) != 0);
            br  = (since_reset > 3) && ($urandom_range(0, 11) == 0);
            tgt = $urandom;
`ifdef FETCH_MISALIGN_CHK_EN
            tgt[1:0] = 2'b00;
`endif
            if ($urandom_range(0, 299) == 0) begin
                doReset(rdy);
            end else begin
                applyStimulus(rdy, br, tgt);
            end
        end
        applyStimulus(1'b1, 1'b0, 32'd0);
        @(posedge clk); #1;
        checkOutput("progress", 32'(delivered >= 500), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded at reset.
REQ-002 Parameter BUF_DEPTH, default 2: instruction buffer entries; legal values 1 or 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 rom_ce  output  1  chip enable to instruction ROM; 1 = enabled.
REQ-006 rom_addr  output  32  byte address to instruction ROM; ROM indexes by addr[..:2].
REQ-007 rom_inst  input  32  instruction word from ROM; combinational, valid in the same cycle as rom_addr.
REQ-008 branch_flag  input  1  redirect request from execute, one cycle.
REQ-009 branch_target  input  32  redirect byte address, sampled when branch_flag=1.
REQ-010 if_valid  output  1  head buffer entry valid toward decode.
REQ-011 if_ready  input  1  decode accepts the head entry this cycle.
REQ-012 if_inst  output  32  head entry instruction.
REQ-013 if_pc  output  32  head entry address.
REQ-014 exc_misalign  output  1  misaligned branch target flag (macro-dependent, REQ-031).

Function
REQ-015 rom_addr SHALL equal the internal pc register; rom_ce SHALL be a registered enable.
REQ-016 rom_ce SHALL be 0 during reset and SHALL become 1 at the first rising edge after rst_n deasserts; pc SHALL hold RESET_PC while rom_ce=0.
REQ-017 Dequeue SHALL occur on an edge where if_valid=1 and if_ready=1.
REQ-018 Fetch SHALL occur on an edge where rom_ce=1, branch_flag=0, fetch not halted, and (count<BUF_DEPTH or dequeue occurs); fetch writes {rom_inst, pc} at the buffer tail and sets pc <= pc+4.
REQ-019 Buffer SHALL be FIFO-ordered; with simultaneous fetch and dequeue, count SHALL remain unchanged.
REQ-020 Full (count=BUF_DEPTH) without dequeue: no fetch, pc held, rom_ce held at 1, rom_addr stable.
REQ-021 Empty: if_valid=0; if_inst and if_pc hold their last values; contents are don't-care.
REQ-022 pc arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 -> 32'h0000_0000.
REQ-023 branch_flag=1: if_valid SHALL be forced 0 combinationally in that cycle; at the edge the buffer is flushed (count=0), pc <= branch_target, and no fetch or dequeue occurs. Branch SHALL take priority over fetch, dequeue and full.
REQ-024 Latency: redirect at edge N; target instruction captured at edge N+1; if_valid=1 with if_pc=target in the cycle after N+1.
REQ-025 Steady state with if_ready=1 continuously: one instruction per cycle, no bubbles.
REQ-026 if_valid SHALL be a function of buffer count and branch_flag only; it SHALL NOT depend on if_ready.

Reset
REQ-027 On rst_n=0, immediately: pc=RESET_PC, rom_ce=0, count=0, if_valid=0, if_inst=0, if_pc=0, exc_misalign=0, halt=0.
REQ-028 Reset asserted mid-operation SHALL discard all buffered entries; no partial state SHALL survive.

Configuration
REQ-029 Macro FETCH_MISALIGN_CHK_EN SHALL select alignment checking.
REQ-030 Without the macro, branch_target[1:0] SHALL be forced to 2'b00 on load, and exc_misalign SHALL be tied 0.
REQ-031 With the macro, a branch with target[1:0]!=0 SHALL load pc unmodified, set exc_misalign=1 (sticky), and halt fetch; the next branch with an aligned target SHALL clear exc_misalign and halt, and fetch SHALL resume per REQ-024.

Verification
REQ-032 Reset release, if_ready=1, ROM word k = k -> if_pc sequence 0,4,8,... with if_inst 0,1,2,..., first if_valid two cycles after rst_n rises.
REQ-033 if_ready=0 for 5 cycles -> count saturates at 2, rom_addr frozen at 0x8; release -> if_pc 0x0,0x4,0x8 delivered in order, none lost or duplicated.
REQ-034 branch_flag with target 0x100 while buffer is full and if_ready=1 -> no dequeue that cycle; next valid if_pc=0x100 two edges later.
REQ-035 RESET_PC=32'hFFFF_FFF8 -> if_pc 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-036 FETCH_MISALIGN_CHK_EN defined, target 0x102 -> exc_misalign=1, if_valid stays 0; then branch to 0x200 -> exc_misalign=0, if_pc=0x200. Macro undefined, target 0x102 -> if_pc=0x100.
REQ-037 rst_n pulsed low for 1 cycle with 2 entries buffered -> if_valid=0 immediately; fetch restarts at RESET_PC.
